// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared constants and encodings for the LCD12864 frame RAM
//               refresh path: frame geometry, RAM widths, arbiter FSM states
//               and arbitration priority encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam int LCD_COLS   = 128;
    localparam int LCD_PAGES  = 8;
    localparam int LCD_ADDR_W = 10;
    localparam int LCD_DATA_W = 8;

    // Refresh arbiter FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } lcd_state_t;

    // Which requester wins the next contended RAM slot
    typedef enum logic {
        PRIO_SCAN = 1'b0,
        PRIO_HOST = 1'b1
    } lcd_prio_t;

endpackage
`default_nettype wire

// File: rtl/lcd_refresh_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lcd_refresh_arbiter
// Description : Shares the single access slot per cycle of the LCD frame RAM
//               between host drawing writes and a refresh scanner. A refresh
//               reads the whole frame in page/column order and streams it
//               over valid/ready towards the SPI display serializer.
// Ports       : CLOCK, RST            - clock, synchronous active-high reset
//               Wr_Req/Addr/Data/Ack  - host write port (Ack combinational)
//               Refresh_Start         - one-cycle pulse starting a frame scan
//               Busy, Done            - scan status (registered)
//               Out_*                 - byte stream with page/last flags
//               Ram_*                 - frame RAM write and read ports
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_refresh_arbiter
    import lcd_pkg::*;
#(
    parameter int COLS   = LCD_COLS,
    parameter int PAGES  = LCD_PAGES,
    parameter int ADDR_W = LCD_ADDR_W,
    parameter int DATA_W = LCD_DATA_W
) (
    input  logic              CLOCK,
    input  logic              RST,
    input  logic              Wr_Req,
    input  logic [ADDR_W-1:0] Wr_Addr,
    input  logic [DATA_W-1:0] Wr_Data,
    output logic              Wr_Ack,
    input  logic              Refresh_Start,
    output logic              Busy,
    output logic              Done,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Out_Data,
    output logic              Out_Page_Start,
    output logic [2:0]        Out_Page,
    output logic              Out_Last,
    output logic              Ram_Write_En,
    output logic [ADDR_W-1:0] Ram_Write_Addr,
    output logic [DATA_W-1:0] Ram_Write_Data,
    output logic [ADDR_W-1:0] Ram_Read_Addr,
    input  logic [DATA_W-1:0] Ram_Read_Data
);

    localparam int                c_COL_W    = $clog2(COLS);
    localparam logic [ADDR_W-1:0] c_MAX_ADDR = ADDR_W'(COLS * PAGES - 1);

    lcd_state_t        r_state;
    lcd_prio_t         r_prio;
    logic [ADDR_W-1:0] r_scan_addr;
    logic [ADDR_W-1:0] r_rd_addr;    // address of the read in flight
    logic [ADDR_W-1:0] r_out_addr;   // address of the byte held in r_out_data
    logic              r_in_flight;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_busy;
    logic              r_done;

    logic w_rd_req;
    logic w_wr_grant;
    logic w_rd_issue;
    logic w_handshake;

    // A read may only be requested when its byte is guaranteed a slot in the
    // output register by the time it returns, so no read data is ever dropped.
    always_comb begin
        w_rd_req    = (r_state == ST_SCAN) && !r_in_flight
                      && (!r_out_valid || Out_Ready);
        w_wr_grant  = Wr_Req && (!w_rd_req || (r_prio == PRIO_HOST));
        w_rd_issue  = w_rd_req && !w_wr_grant;
        w_handshake = r_out_valid && Out_Ready;
    end

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_prio      <= PRIO_SCAN;
            r_scan_addr <= '0;
            r_rd_addr   <= '0;
            r_out_addr  <= '0;
            r_in_flight <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Only a contended slot hands priority to the loser
            if (w_rd_req && Wr_Req) begin
                r_prio <= (r_prio == PRIO_SCAN) ? PRIO_HOST : PRIO_SCAN;
            end

            if (w_rd_issue) begin
                r_in_flight <= 1'b1;
                r_rd_addr   <= r_scan_addr;
                r_scan_addr <= r_scan_addr + 1'b1;
            end

            // The output register is always empty when a read returns, so the
            // capture never collides with a pending handshake.
            if (r_in_flight) begin
                r_in_flight <= 1'b0;
                r_out_valid <= 1'b1;
                r_out_data  <= Ram_Read_Data;
                r_out_addr  <= r_rd_addr;
            end else if (w_handshake) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (Refresh_Start) begin
                        r_state     <= ST_SCAN;
                        r_scan_addr <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (w_rd_issue && (r_scan_addr == c_MAX_ADDR)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_handshake && (r_out_addr == c_MAX_ADDR)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Wr_Ack         = w_wr_grant;
    assign Ram_Write_En   = w_wr_grant;
    assign Ram_Write_Addr = Wr_Addr;
    assign Ram_Write_Data = Wr_Data;
    assign Ram_Read_Addr  = r_scan_addr;

    assign Busy           = r_busy;
    assign Done           = r_done;
    assign Out_Valid      = r_out_valid;
    assign Out_Data       = r_out_data;
    assign Out_Page       = 3'(r_out_addr >> c_COL_W);
    assign Out_Page_Start = (r_out_addr[c_COL_W-1:0] == '0);
    assign Out_Last       = (r_out_addr == c_MAX_ADDR);

endmodule
`default_nettype wire

// File: tb/tb_lcd_refresh_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_refresh_arbiter
// Description : Self-checking bench for lcd_refresh_arbiter with a behavioural
//               frame RAM, a byte scoreboard and directed refresh scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_refresh_arbiter;
    import lcd_pkg::*;

    localparam int N  = LCD_COLS * LCD_PAGES;
    localparam int AW = LCD_ADDR_W;
    localparam int DW = LCD_DATA_W;

    logic          CLOCK;
    logic          RST;
    logic          Wr_Req;
    logic [AW-1:0] Wr_Addr;
    logic [DW-1:0] Wr_Data;
    logic          Wr_Ack;
    logic          Refresh_Start;
    logic          Busy;
    logic          Done;
    logic          Out_Valid;
    logic          Out_Ready;
    logic [DW-1:0] Out_Data;
    logic          Out_Page_Start;
    logic [2:0]    Out_Page;
    logic          Out_Last;
    logic          Ram_Write_En;
    logic [AW-1:0] Ram_Write_Addr;
    logic [DW-1:0] Ram_Write_Data;
    logic [AW-1:0] Ram_Read_Addr;
    logic [DW-1:0] Ram_Read_Data;

    lcd_refresh_arbiter #(
        .COLS   (LCD_COLS),
        .PAGES  (LCD_PAGES),
        .ADDR_W (LCD_ADDR_W),
        .DATA_W (LCD_DATA_W)
    ) dut (
        .CLOCK          (CLOCK),
        .RST            (RST),
        .Wr_Req         (Wr_Req),
        .Wr_Addr        (Wr_Addr),
        .Wr_Data        (Wr_Data),
        .Wr_Ack         (Wr_Ack),
        .Refresh_Start  (Refresh_Start),
        .Busy           (Busy),
        .Done           (Done),
        .Out_Valid      (Out_Valid),
        .Out_Ready      (Out_Ready),
        .Out_Data       (Out_Data),
        .Out_Page_Start (Out_Page_Start),
        .Out_Page       (Out_Page),
        .Out_Last       (Out_Last),
        .Ram_Write_En   (Ram_Write_En),
        .Ram_Write_Addr (Ram_Write_Addr),
        .Ram_Write_Data (Ram_Write_Data),
        .Ram_Read_Addr  (Ram_Read_Addr),
        .Ram_Read_Data  (Ram_Read_Data)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Frame RAM: registered read data, refreshed only in non-write cycles
    logic [DW-1:0] ram [N];
    always @(posedge CLOCK) begin
        if (Ram_Write_En) ram[Ram_Write_Addr] <= Ram_Write_Data;
        else              Ram_Read_Data       <= ram[Ram_Read_Addr];
    end

    typedef struct packed {
        logic          last;
        logic          ps;
        logic [2:0]    page;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        logic          req;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          exp_ack;
    } wvec_t;

    exp_t          sb[$];
    logic [DW-1:0] frame [N];
    wvec_t         wv [6];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt, busy_cnt, hs_cnt, done_cyc;
    int wait_run, max_wait;
    int wptr;

    logic          held_valid = 1'b0;
    exp_t          held_vec;
    logic          s_ack, s_we, s_busy, s_done, s_valid;
    logic [AW-1:0] s_waddr, s_raddr;
    logic [DW-1:0] s_wdata, s_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event did not occur within its cycle budget (cycle %0d)", name, cyc);
    endtask

    // One clock: sample and score at the falling edge, then return just
    // after the rising edge so the caller can drive the next inputs.
    task automatic cycle();
        exp_t cur;
        exp_t e;
        @(negedge CLOCK);
        cyc++;
        cur     = {Out_Last, Out_Page_Start, Out_Page, Out_Data};
        s_ack   = Wr_Ack;
        s_we    = Ram_Write_En;
        s_waddr = Ram_Write_Addr;
        s_wdata = Ram_Write_Data;
        s_raddr = Ram_Read_Addr;
        s_busy  = Busy;
        s_done  = Done;
        s_valid = Out_Valid;
        s_data  = Out_Data;
        if (!RST) begin
            if (Done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (Busy === 1'b1) busy_cnt++;
            if (held_valid) chk("stall_hold", {Out_Valid, cur}, {1'b1, held_vec});
            if (Out_Valid === 1'b1 && Out_Ready) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL extra_byte: got byte %0h, expected no byte (cycle %0d)", Out_Data, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("byte", cur, e);
                end
            end
            if (Wr_Req && Wr_Ack !== 1'b1) wait_run++;
            else                           wait_run = 0;
            if (wait_run > max_wait) max_wait = wait_run;
        end
        held_valid = (Out_Valid === 1'b1) && !Out_Ready && !RST;
        held_vec   = cur;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic push_frame();
        exp_t e;
        for (int a = 0; a < N; a++) begin
            e.data = frame[a];
            e.page = 3'(a / LCD_COLS);
            e.ps   = (a % LCD_COLS) == 0;
            e.last = (a == N - 1);
            sb.push_back(e);
        end
    endtask

    task automatic start_scan();
        push_frame();
        done_cnt      = 0;
        busy_cnt      = 0;
        hs_cnt        = 0;
        Refresh_Start = 1'b1;
        cycle();
        Refresh_Start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            cycle();
            n++;
        end
        if (done_cnt == 0) fail_now(name);
        repeat (4) cycle();
    endtask

    task automatic writer_step();
        if (Wr_Req && s_ack === 1'b1) begin
            wptr    = (wptr == N - 1) ? N / 2 : wptr + 1;
            Wr_Addr = AW'(wptr);
            Wr_Data = DW'(wptr) ^ 8'h5A;
        end
    endtask

    initial begin
        int n;
        int misses;
        int c0;

        wv[0] = '{req: 1'b1, addr: 10'h005, data: 8'hA5, exp_ack: 1'b1};
        wv[1] = '{req: 1'b0, addr: 10'h006, data: 8'h11, exp_ack: 1'b0};
        wv[2] = '{req: 1'b1, addr: 10'h3FF, data: 8'h5A, exp_ack: 1'b1};
        wv[3] = '{req: 1'b1, addr: 10'h000, data: 8'hC3, exp_ack: 1'b1};
        wv[4] = '{req: 1'b0, addr: 10'h080, data: 8'hFF, exp_ack: 1'b0};
        wv[5] = '{req: 1'b1, addr: 10'h200, data: 8'h00, exp_ack: 1'b1};

        RST = 1'b1; Wr_Req = 1'b0; Wr_Addr = '0; Wr_Data = '0;
        Refresh_Start = 1'b0; Out_Ready = 1'b1;
        done_cnt = 0; busy_cnt = 0; hs_cnt = 0; done_cyc = 0;
        wait_run = 0; max_wait = 0; wptr = 0;
        repeat (3) cycle();
        RST = 1'b0;
        cycle();
        chk("reset_busy",  32'(s_busy),  0);
        chk("reset_done",  32'(s_done),  0);
        chk("reset_valid", 32'(s_valid), 0);
        chk("reset_data",  32'(s_data),  0);
        chk("reset_ack",   32'(s_ack),   0);

        // Idle writes: granted in the same cycle, address/data passed through
        for (int i = 0; i < 6; i++) begin
            Wr_Req  = wv[i].req;
            Wr_Addr = wv[i].addr;
            Wr_Data = wv[i].data;
            cycle();
            chk("idle_wr_ack",   32'(s_ack),   32'(wv[i].exp_ack));
            chk("idle_ram_we",   32'(s_we),    32'(wv[i].exp_ack));
            chk("idle_ram_addr", 32'(s_waddr), 32'(wv[i].addr));
            chk("idle_ram_data", 32'(s_wdata), 32'(wv[i].data));
        end
        Wr_Req = 1'b0;

        // Preload byte = addr[7:0] through the host port
        misses = 0;
        for (int a = 0; a < N; a++) begin
            Wr_Req   = 1'b1;
            Wr_Addr  = AW'(a);
            Wr_Data  = DW'(a);
            frame[a] = DW'(a);
            cycle();
            if (s_ack !== 1'b1) misses++;
        end
        Wr_Req = 1'b0;
        chk("preload_acks", misses, 0);

        // Full scan with latency probes and a stray Refresh_Start mid-scan
        start_scan();
        c0 = cyc;
        cycle();
        chk("lat_busy_k1",  32'(s_busy),  1);
        chk("lat_valid_k1", 32'(s_valid), 0);
        cycle();
        chk("lat_valid_k2", 32'(s_valid), 0);
        cycle();
        chk("lat_valid_k3", 32'(s_valid), 1);
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            Refresh_Start = (n == 500);
            cycle();
            n++;
        end
        Refresh_Start = 1'b0;
        if (done_cnt == 0) fail_now("scan1_timeout");
        repeat (4) cycle();
        chk("scan1_done_count",  done_cnt, 1);
        chk("scan1_done_cycle",  done_cyc - c0, 2050);
        chk("scan1_busy_cycles", busy_cnt, 2049);
        chk("scan1_bytes",       hs_cnt, N);
        chk("scan1_sb_empty",    sb.size(), 0);

        // Contention: host keeps rewriting the upper half with a new pattern
        for (int a = N / 2; a < N; a++) frame[a] = DW'(a) ^ 8'h5A;
        wptr     = N / 2;
        Wr_Req   = 1'b1;
        Wr_Addr  = AW'(wptr);
        Wr_Data  = DW'(wptr) ^ 8'h5A;
        wait_run = 0;
        max_wait = 0;
        start_scan();
        writer_step();
        n = 0;
        while (done_cnt == 0 && n < 5000) begin
            cycle();
            writer_step();
            n++;
        end
        Wr_Req = 1'b0;
        if (done_cnt == 0) fail_now("scan2_timeout");
        repeat (4) cycle();
        chk("scan2_done_count", done_cnt, 1);
        chk("scan2_bytes",      hs_cnt, N);
        chk("scan2_sb_empty",   sb.size(), 0);
        chk("scan2_wr_wait_max", max_wait, 1);

        // Backpressure: Out_Ready toggles every 3 cycles
        start_scan();
        n = 0;
        while (done_cnt == 0 && n < 10000) begin
            Out_Ready = ((n / 3) % 2) == 0;
            cycle();
            n++;
        end
        Out_Ready = 1'b1;
        if (done_cnt == 0) fail_now("scan3_timeout");
        repeat (4) cycle();
        chk("scan3_done_count", done_cnt, 1);
        chk("scan3_bytes",      hs_cnt, N);
        chk("scan3_sb_empty",   sb.size(), 0);

        // Reset after byte 300: scan aborted, no Done
        start_scan();
        n = 0;
        while (hs_cnt < 300 && n < 2000) begin
            cycle();
            n++;
        end
        if (hs_cnt < 300) fail_now("scan4_byte300_timeout");
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        sb.delete();
        done_cnt = 0;
        hs_cnt   = 0;
        cycle();
        chk("abort_busy",  32'(s_busy),  0);
        chk("abort_done",  32'(s_done),  0);
        chk("abort_valid", 32'(s_valid), 0);
        chk("abort_data",  32'(s_data),  0);
        chk("abort_raddr", 32'(s_raddr), 0);
        chk("abort_ack",   32'(s_ack),   0);
        repeat (40) cycle();
        chk("abort_no_done",  done_cnt, 0);
        chk("abort_no_bytes", hs_cnt, 0);

        // Fresh scan after the abort starts again from address 0
        start_scan();
        wait_done(3000, "scan5_timeout");
        chk("scan5_done_count", done_cnt, 1);
        chk("scan5_bytes",      hs_cnt, N);
        chk("scan5_sb_empty",   sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
